// File: rtl/ts_packet_switch.sv
// ts_packet_switch
// ----------------
// N-channel MPEG-2 TS packet switch. It forwards the byte stream of one input
// channel as a single {valid, sync, data} output. A channel change only takes
// effect on a packet boundary, so every forwarded packet is complete and starts
// with a sync byte. Packet length is tracked per active stream. Short packets and
// lost sync are reported as sync errors.
//
// Parameters
//   NUM_CH      number of input TS channels (2..16)
//   DATA_WIDTH  TS byte width
//   SEL_W       channel select width, 2**SEL_W >= NUM_CH
//   PKT_LEN     packet length in bytes (>= 4)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   sel_in          requested channel; values >= NUM_CH are rejected
//   data_in         channel k byte at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in        byte-valid per channel
//   sync_in         per channel: byte is a packet sync byte, qualified by valid_in
//   data_out_final  registered {valid, sync, data}; sync/data hold while not valid
//   active_ch       channel currently forwarded
//   switch_pending  registered select differs from active_ch
//   pkt_done        pulse with the last byte of a full packet
//   sync_err        pulse on short packet (with its byte) or lost sync (dropped byte)
//   sel_err         pulse one cycle after an out-of-range sel_in sample

module ts_packet_switch #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned PKT_LEN    = 188
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             sel_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            valid_in,
  input  logic [NUM_CH-1:0]            sync_in,
  output logic [DATA_WIDTH+1:0]        data_out_final,
  output logic [SEL_W-1:0]             active_ch,
  output logic                         switch_pending,
  output logic                         pkt_done,
  output logic                         sync_err,
  output logic                         sel_err
);

  localparam int unsigned CntW = $clog2(PKT_LEN + 1);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StFwd    = 2'd1,
    StSwitch = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_reg_q, sel_reg_d;
  logic [SEL_W-1:0]      active_ch_q, active_ch_d;
  logic [DATA_WIDTH+1:0] out_q, out_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  sync_err_q, sync_err_d;
  logic                  sel_err_q, sel_err_d;

  logic                  sel_ok;
  logic [SEL_W-1:0]      obs_ch;
  logic                  obs_valid;
  logic                  obs_sync;
  logic [DATA_WIDTH-1:0] obs_data;

  // Decisions of the next-state process, consumed by the output process.
  logic                  fwd;
  logic                  done;
  logic                  err;

  // Select register: out-of-range requests are ignored and flagged.
  always_comb begin
    sel_ok    = (32'(sel_in) < NUM_CH);
    sel_reg_d = sel_ok ? sel_in : sel_reg_q;
    sel_err_d = ~sel_ok;
  end

  // While locked, only the active channel is observed. While hunting or switching,
  // the registered select is watched directly, so a sync byte on the new channel
  // is caught in the same cycle that active_ch is retargeted.
  always_comb begin
    obs_ch    = (state_q == StFwd) ? active_ch_q : sel_reg_q;
    obs_valid = 1'b0;
    obs_sync  = 1'b0;
    obs_data  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (obs_ch == SEL_W'(k)) begin
        obs_valid = valid_in[k];
        obs_sync  = sync_in[k];
        obs_data  = data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      sel_reg_q   <= '0;
      active_ch_q <= '0;
      out_q       <= '0;
      pkt_done_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_reg_q   <= sel_reg_d;
      active_ch_q <= active_ch_d;
      out_q       <= out_d;
      pkt_done_q  <= pkt_done_d;
      sync_err_q  <= sync_err_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Next-state logic: packet framing and channel hand-over.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_ch_d = active_ch_q;
    fwd         = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      // HUNT and SWITCH behave alike: follow sel_reg and lock on its next sync byte.
      StHunt, StSwitch: begin
        active_ch_d = sel_reg_q;
        if (obs_valid && obs_sync) begin
          fwd     = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StFwd;
        end
      end
      StFwd: begin
        if (obs_valid) begin
          if (cnt_q < CntW'(PKT_LEN)) begin
            fwd = 1'b1;
            if (obs_sync) begin
              // Short packet: the sync byte starts a fresh packet.
              err   = 1'b1;
              cnt_d = CntW'(1);
            end else begin
              cnt_d = cnt_q + CntW'(1);
              if (cnt_q == CntW'(PKT_LEN - 1)) begin
                done = 1'b1;
                if (sel_reg_q != active_ch_q) begin
                  state_d = StSwitch;
                end
              end
            end
          end else if (obs_sync) begin
            fwd   = 1'b1;
            cnt_d = CntW'(1);
          end else begin
            // Lost sync: drop the byte and re-acquire.
            err     = 1'b1;
            cnt_d   = '0;
            state_d = StHunt;
          end
        end
      end
      default: begin
        state_d = StHunt;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: registered byte plus aligned event pulses.
  always_comb begin
    out_d[DATA_WIDTH+1]  = fwd;
    out_d[DATA_WIDTH]    = fwd ? obs_sync : out_q[DATA_WIDTH];
    out_d[DATA_WIDTH-1:0] = fwd ? obs_data : out_q[DATA_WIDTH-1:0];
    pkt_done_d           = done;
    sync_err_d           = err;
  end

  assign data_out_final = out_q;
  assign active_ch      = active_ch_q;
  assign switch_pending = (sel_reg_q != active_ch_q);
  assign pkt_done       = pkt_done_q;
  assign sync_err       = sync_err_q;
  assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_ts_packet_switch.sv
// Self-checking bench for ts_packet_switch (3 channels, so select value 3 is
// out of range). Per-channel packet generators feed the DUT. A reference model
// works on "hunting / bytes-in-packet" terms and predicts every registered output.
// Directed phases then check the event counts for each scenario.

module tb_ts_packet_switch;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam int L   = 188;

  logic              clk = 1'b0;
  logic              rst;
  logic [SW-1:0]     sel_in;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    valid_in;
  logic [NCH-1:0]    sync_in;
  logic [DW+1:0]     data_out_final;
  logic [SW-1:0]     active_ch;
  logic              switch_pending;
  logic              pkt_done;
  logic              sync_err;
  logic              sel_err;

  ts_packet_switch #(
    .NUM_CH    (NCH),
    .DATA_WIDTH(DW),
    .SEL_W     (SW),
    .PKT_LEN   (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_in        (sel_in),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .sync_in       (sync_in),
    .data_out_final(data_out_final),
    .active_ch     (active_ch),
    .switch_pending(switch_pending),
    .pkt_done      (pkt_done),
    .sync_err      (sync_err),
    .sel_err       (sel_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Per-phase observation counters.
  int n_valid, n_sync, n_done, n_err, n_pend, n_restart;
  bit prev_v;

  // Stream generators: position within packet, current packet length, fault requests.
  int g_pos[NCH];
  int g_len[NCH];
  bit g_short[NCH];
  bit g_lost[NCH];
  bit g_junk[NCH];

  // Reference model.
  bit       m_hunt;
  int       m_pos;
  int       m_cur;
  int       m_sel;
  bit       e_valid, e_sync, e_done, e_err, e_selerr;
  bit [7:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_reset();
    for (int c = 0; c < NCH; c++) begin
      g_pos[c]   = 0;
      g_len[c]   = L;
      g_short[c] = 1'b0;
      g_lost[c]  = 1'b0;
      g_junk[c]  = 1'b0;
    end
  endtask

  task automatic gen_byte(input int c, output logic s, output logic [7:0] d);
    if (g_junk[c]) begin
      g_junk[c] = 1'b0;
      s = 1'b0;
      d = 8'($urandom_range(0, 255));
    end else begin
      s = (g_pos[c] == 0);
      d = s ? 8'h47 : 8'($urandom_range(0, 255));
      g_pos[c]++;
      if (g_pos[c] >= g_len[c]) begin
        g_pos[c]   = 0;
        g_len[c]   = g_short[c] ? 100 : L;
        g_short[c] = 1'b0;
        if (g_lost[c]) begin
          g_junk[c] = 1'b1;
          g_lost[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_hunt = 1'b1; m_pos = 0; m_cur = 0; m_sel = 0;
    e_valid = 0; e_sync = 0; e_data = '0; e_done = 0; e_err = 0; e_selerr = 0;
  endtask

  // One clock of the reference model, from the inputs currently driven.
  task automatic model_step();
    int       ch;
    bit       v, s, f;
    bit [7:0] d;
    f        = 1'b0;
    e_done   = 1'b0;
    e_err    = 1'b0;
    e_selerr = (int'(sel_in) >= NCH);
    ch = m_hunt ? m_sel : m_cur;
    v  = valid_in[ch];
    s  = sync_in[ch];
    d  = data_in[ch*DW +: DW];
    if (m_hunt) begin
      m_cur = m_sel;
      if (v && s) begin
        f = 1'b1; m_pos = 1; m_hunt = 1'b0;
      end
    end else if (v) begin
      if (m_pos < L) begin
        f = 1'b1;
        if (s) begin
          e_err = 1'b1; m_pos = 1;
        end else begin
          m_pos++;
          if (m_pos == L) begin
            e_done = 1'b1;
            if (m_sel != m_cur) m_hunt = 1'b1;
          end
        end
      end else if (s) begin
        f = 1'b1; m_pos = 1;
      end else begin
        e_err = 1'b1; m_pos = 0; m_hunt = 1'b1;
      end
    end
    e_valid = f;
    if (f) begin
      e_sync = s;
      e_data = d;
    end
    if (int'(sel_in) < NCH) m_sel = int'(sel_in);
  endtask

  task automatic clear_counts();
    n_valid = 0; n_sync = 0; n_done = 0; n_err = 0; n_pend = 0; n_restart = 0;
  endtask

  // Drive one cycle of input (channels in mask, valid with prob percent), step the
  // model, clock, then compare every output one time unit after the edge.
  task automatic do_cycle(input int mask, input int prob);
    logic [NCH-1:0]    vv, ss;
    logic [NCH*DW-1:0] dd;
    logic              s;
    logic [7:0]        d;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c] && ($urandom_range(0, 99) < prob)) begin
        gen_byte(c, s, d);
        vv[c] = 1'b1;
      end else begin
        s = 1'($urandom_range(0, 1));
        d = 8'($urandom_range(0, 255));
        vv[c] = 1'b0;
      end
      ss[c] = s;
      dd[c*DW +: DW] = d;
    end
    valid_in = vv;
    sync_in  = ss;
    data_in  = dd;
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    chk("data_out_final", 32'(data_out_final), 32'({e_valid, e_sync, e_data}));
    chk("active_ch", 32'(active_ch), 32'(m_cur));
    chk("switch_pending", 32'(switch_pending), 32'(m_sel != m_cur));
    chk("pkt_done", 32'(pkt_done), 32'(e_done));
    chk("sync_err", 32'(sync_err), 32'(e_err));
    chk("sel_err", 32'(sel_err), 32'(e_selerr));
    n_valid += int'(data_out_final[DW+1]);
    n_sync  += int'(data_out_final[DW+1] & data_out_final[DW]);
    n_done  += int'(pkt_done);
    n_err   += int'(sync_err);
    n_pend  += int'(switch_pending);
    if (data_out_final[DW+1] && !prev_v && !data_out_final[DW]) n_restart++;
    prev_v = data_out_final[DW+1];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out_final"}, 32'(data_out_final), 32'd0);
    chk({tag, "_active_ch"}, 32'(active_ch), 32'd0);
    chk({tag, "_switch_pending"}, 32'(switch_pending), 32'd0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    chk({tag, "_sel_err"}, 32'(sel_err), 32'd0);
  endtask

  initial begin
    logic [SW-1:0] act;
    logic [DW+1:0] prev_out;
    int            i;

    rst      = 1'b1;
    sel_in   = '0;
    valid_in = '0;
    sync_in  = '0;
    data_in  = '0;
    prev_v   = 1'b0;
    gen_reset();
    model_reset();
    clear_counts();

    // Reset state.
    do_cycle(0, 0);
    do_cycle(0, 0);
    chk_all_zero("reset");
    #3 rst = 1'b0;

    // Steady forward: three full packets on channel 0.
    clear_counts();
    for (int k = 0; k < 3 * L; k++) do_cycle(1, 100);
    do_cycle(0, 0);
    do_cycle(0, 0);
    chk("steady_bytes", 32'(n_valid), 32'd564);
    chk("steady_sync", 32'(n_sync), 32'd3);
    chk("steady_done", 32'(n_done), 32'd3);
    chk("steady_err", 32'(n_err), 32'd0);

    // Mid-packet switch 0 -> 2 at byte 50, all channels streaming with offsets.
    g_pos[1] = 30;
    g_pos[2] = 100;
    clear_counts();
    for (int k = 0; k < 600; k++) begin
      if (sel_in == 2'd0 && g_pos[0] == 50) sel_in = 2'd2;
      do_cycle(7, 100);
    end
    chk("switch_pending_cycles", 32'(n_pend), 32'd138);
    chk("switch_err", 32'(n_err), 32'd0);
    chk("switch_restart_sync", 32'(n_restart), 32'd0);
    chk("switch_active", 32'(active_ch), 32'd2);

    // Short packet on channel 1.
    sel_in = 2'd1;
    i = 0;
    while (i < 1500 && !(active_ch == 2'd1 && data_out_final[DW+1])) begin
      do_cycle(7, 100);
      i++;
    end
    chk("short_lock", 32'(active_ch == 2'd1 && data_out_final[DW+1]), 32'd1);
    g_short[1] = 1'b1;
    clear_counts();
    for (int k = 0; k < 600; k++) do_cycle(7, 100);
    chk("short_err", 32'(n_err), 32'd1);
    chk("short_done_after", 32'(n_done >= 2), 32'd1);

    // Lost sync on channel 0.
    sel_in = 2'd0;
    i = 0;
    while (i < 1500 && !(active_ch == 2'd0 && data_out_final[DW+1])) begin
      do_cycle(7, 100);
      i++;
    end
    chk("lost_lock", 32'(active_ch == 2'd0 && data_out_final[DW+1]), 32'd1);
    g_lost[0] = 1'b1;
    clear_counts();
    for (int k = 0; k < 600; k++) do_cycle(7, 100);
    chk("lost_err", 32'(n_err), 32'd1);
    chk("lost_restart_sync", 32'(n_restart), 32'd0);

    // Invalid select: 3 is out of range for three channels.
    do_cycle(0, 0);
    do_cycle(0, 0);
    act      = active_ch;
    prev_out = data_out_final;
    sel_in   = 2'd3;
    do_cycle(0, 0);
    chk("badsel_sel_err", 32'(sel_err), 32'd1);
    chk("badsel_active", 32'(active_ch), 32'(act));
    chk("badsel_out", 32'(data_out_final), 32'(prev_out));
    sel_in = 2'd0;
    do_cycle(0, 0);
    chk("badsel_clear", 32'(sel_err), 32'd0);

    // Asynchronous reset at byte 80 of a channel-0 packet.
    i = 0;
    while (i < 400 && g_pos[0] != 80) begin
      do_cycle(1, 100);
      i++;
    end
    chk("rst_reach_byte80", 32'(g_pos[0]), 32'd80);
    chk("rst_locked", 32'(data_out_final[DW+1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    model_reset();
    prev_v = 1'b0;
    do_cycle(1, 100);
    do_cycle(1, 100);
    #2 rst = 1'b0;
    clear_counts();
    for (int k = 0; k < 400; k++) do_cycle(1, 100);
    chk("rst_restart_sync", 32'(n_restart), 32'd0);
    chk("rst_resumed", 32'(n_valid > 0), 32'd1);

    // Random traffic: gaps, select changes (including out-of-range), injected faults.
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 199) == 0) sel_in = 2'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 2999) == 0) g_short[c] = 1'b1;
        if ($urandom_range(0, 2999) == 0) g_lost[c] = 1'b1;
      end
      do_cycle(7, 80);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
